// File: rtl/bcd_to_bin.sv
// bcd_to_bin: serial packed-BCD to binary converter, one digit per cycle, MSD first.
// Latency: out_valid rises NDIG cycles after the accepting edge; one bubble cycle between results.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
// Build option: define BCD_TO_BIN_CHECK_EN to flag digits above 9 on err (bin_out unaffected).
module bcd_to_bin #(
    parameter int NDIG  = 4,
    parameter int BIN_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  bin_out,
    output logic              err
);

    // Counter must be able to hold NDIG itself after the last digit.
    localparam int CNT_W = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [4*NDIG-1:0] sreg;
    logic [BIN_W-1:0]  acc;
    logic [BIN_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        digit;
    logic              accept;
    logic              last_digit;

    assign accept     = (state == IDLE) && in_valid;
    assign digit      = sreg[4*NDIG-1 -: 4];
    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    // acc*10 + d as shift-and-add; truncation to BIN_W gives the modulo wrap.
    // Digits 10..15 are accumulated with their raw value on purpose.
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);

    assign bin_out = acc;

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: in_valid is only looked at in IDLE, so a request
    // arriving in CONV/DONE stays with the producer until we return.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = CONV;
            CONV: if (last_digit) state_nxt = DONE;
            DONE: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, then one digit per CONV cycle; frozen in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bcd_in;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == CONV) begin
            acc  <= acc_nxt;
            sreg <= sreg << 4;
            cnt  <= cnt + CNT_W'(1);
        end
    end

`ifdef BCD_TO_BIN_CHECK_EN
    logic err_q;

    // Sticky invalid-digit flag, cleared when the next request is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == CONV) && (digit > 4'd9)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter NDIG, default 4: number of packed BCD digits at the input.
REQ-002 Parameter BIN_W, default 14: binary output width; must satisfy 2^BIN_W > 10^NDIG - 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  bcd_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a conversion request.
REQ-007 bcd_in  input  4*NDIG  packed BCD number; most significant digit in the top nibble.
REQ-008 out_valid  output  1  bin_out and err hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bin_out  output  BIN_W  binary value of the captured BCD number.
REQ-011 err  output  1  a captured digit exceeded 9; meaningful only while out_valid=1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 exactly when state=IDLE; out_valid SHALL be 1 exactly when state=DONE.
REQ-014 In IDLE, when in_valid=1, the block SHALL capture bcd_in into a shift register, clear the accumulator, the digit counter and err, and enter CONV.
REQ-015 In IDLE, when in_valid=0, the block SHALL remain in IDLE and ignore bcd_in.
REQ-016 Each CONV cycle SHALL process the top nibble d: acc <= acc*10 + d, computed modulo 2^BIN_W; shift the register left by 4; increment the counter.
REQ-017 After the NDIG-th digit the block SHALL enter DONE, so out_valid rises on the NDIG-th rising edge after the accepting edge.
REQ-018 In DONE, bin_out and err SHALL stay stable until the edge on which out_ready=1, at which the block returns to IDLE.
REQ-019 in_valid SHALL have no effect in CONV or DONE; a request presented there SHALL NOT be lost, and the producer holds it.
REQ-020 If out_ready=1 and in_valid=1 in the same DONE cycle, the block SHALL go to IDLE and accept the new request no earlier than the next edge (one-cycle bubble).
REQ-021 bin_out SHALL equal acc at all times; it is defined for use only while out_valid=1.
REQ-022 A digit d > 9 SHALL be accumulated with its raw value 10..15; it SHALL NOT be saturated or skipped.

Reset
REQ-023 While rst=1 the state SHALL be IDLE, with acc, the shift register, the counter, bin_out, err and out_valid at 0, and in_ready at 1.
REQ-024 Reset asserted in CONV or DONE SHALL abandon the conversion immediately, with no partial result presented.
REQ-025 After rst deasserts, the first in_valid SHALL be accepted on the first following edge.

Configuration
REQ-026 Macro BCD_TO_BIN_CHECK_EN SHALL select digit checking.
- Defined: err is set (sticky until the next accept) on any CONV cycle where d > 9.
- Not defined: err is tied to 0 and no compare logic is synthesized.
- bin_out is identical in both builds.

Verification (NDIG=4, BIN_W=14)
REQ-027 bcd_in=16'h0000, accept -> out_valid exactly 4 cycles later, bin_out=0, err=0.
REQ-028 bcd_in=16'h9999 -> bin_out=9999 (14'h270F), err=0; bcd_in=16'h1234 -> bin_out=1234.
REQ-029 After 16'h0507 completes, hold out_ready=0 for 3 cycles:
- bin_out stays 507 and out_valid stays 1;
- in_ready stays 0, and in_valid with 16'h1111 is not accepted.
REQ-030 With the macro defined, bcd_in=16'h12A4 -> err=1, bin_out=1304. Without the macro, same stimulus -> err=0, bin_out=1304.
REQ-031 Pulse rst during the second CONV cycle of 16'h8888:
- out_valid=0 and in_ready=1 immediately;
- a following 16'h0042 -> bin_out=42, err=0.
REQ-032 Back-to-back requests, with out_ready=1 and in_valid=1 in the same DONE cycle:
- 16'h0001 then 16'h0002 -> results 1 then 2, in order;
- the second request is accepted one cycle after the first result leaves.
